uart_tx_fifo: RTL and testbench

- Buffered UART transmitter, 8N1/8N2, LSB first.
- Accepts bytes from fabric logic over a valid/ready handshake and queues them in a small synchronous FIFO.
- Serialises bytes onto the board UART_TX pin at a fixed baud rate.
- Transmit-side counterpart to the UART receive path; top level drives uarttx from its tx output.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_fifo_if.sv | 12 +
 rtl/sync_fifo.sv | 75 +++++++
 rtl/uart_tx_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, frame constants and the baud divider helper.
// Used by both the transmit and receive paths.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t ST_IDLE  = 2'd0;
  localparam uart_state_t ST_START = 2'd1;
  localparam uart_state_t ST_DATA  = 2'd2;
  localparam uart_state_t ST_STOP  = 2'd3;

  // Clock cycles per bit, truncated; callers must keep the result >= 2.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-wide valid/ready handshake from fabric logic into the UART transmit FIFO.
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] din;
  logic                 din_valid;
  logic                 din_ready;

  modport master (output din, output din_valid, input  din_ready);
  modport slave  (input  din, input  din_valid, output din_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; full/empty derive from the occupancy count.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     reset_trigger,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_wr_s, do_rd_s;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr_s = wr_en && !full;
  assign do_rd_s = rd_en && !empty;

  // Next-state pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_rd_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_wr_s, do_rd_s})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK or posedge reset_trigger) begin
    if (reset_trigger) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8N2 UART transmitter: FIFO-fed FSM serialising LSB first onto a registered tx line.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int DEPTH     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                   CLK,
  input  logic                   reset_trigger,
  uart_tx_fifo_if.slave          din_if,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [2:0]    LAST_DATA_BIT = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP_BIT = 3'(STOP_BITS - 1);

  uart_state_t          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_q, bit_d;
  logic                 tx_q, tx_d;

  logic                 pop_s;
  logic                 bit_end_s;
  logic [DATA_BITS-1:0] head_s;
  logic                 full_s;
  logic                 empty_s;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .CLK           (CLK),
    .reset_trigger (reset_trigger),
    .wr_en         (din_if.din_valid),
    .wr_data       (din_if.din),
    .rd_en         (pop_s),
    .rd_data       (head_s),
    .full          (full_s),
    .empty         (empty_s),
    .level         (level)
  );

  // Ready is taken from the pre-edge full flag only; a same-cycle pop never opens it early.
  assign din_if.din_ready = !full_s;
  assign bit_end_s        = (cnt_q == CNT_LAST);
  assign tx               = tx_q;
  assign busy             = (state_q != ST_IDLE) || !empty_s;

  // Frame sequencing: start bit, eight data bits LSB first, stop bit(s), back-to-back when data waits.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end_s ? '0 : cnt_q + CW'(1);
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = head_s;
          tx_d    = 1'b0;
          state_d = ST_START;
        end else begin
          tx_d    = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          tx_d    = shift_q[0];
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          tx_d    = 1'b0;
        end
      end
      ST_DATA: begin
        if (bit_end_s && (bit_q == LAST_DATA_BIT)) begin
          tx_d    = 1'b1;
          bit_d   = 3'd0;
          state_d = ST_STOP;
        end else if (bit_end_s) begin
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
          bit_d   = bit_q + 3'd1;
        end else begin
          tx_d    = tx_q;
        end
      end
      ST_STOP: begin
        if (bit_end_s && (bit_q == LAST_STOP_BIT)) begin
          bit_d = 3'd0;
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_d = head_s;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (bit_end_s) begin
          bit_d = bit_q + 3'd1;
          tx_d  = 1'b1;
        end else begin
          tx_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FSM, baud counter, shift register and line register; reset drops the line high immediately.
  always_ff @(posedge CLK or posedge reset_trigger) begin
    if (reset_trigger) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: two instances (one and two stop bits) against a queue-based line model.
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 250_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic CLK = 1'b0;
  logic reset_trigger;
  always #5 CLK = ~CLK;

  uart_tx_fifo_if if0 ();
  uart_tx_fifo_if if1 ();

  logic [1:0]    tx_w, busy_w, rdy_w;
  logic [LW-1:0] lvl_w [2];

  assign rdy_w = {if1.din_ready, if0.din_ready};

  uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .STOP_BITS(1)) dut0 (
    .CLK (CLK), .reset_trigger (reset_trigger), .din_if (if0),
    .tx (tx_w[0]), .busy (busy_w[0]), .level (lvl_w[0])
  );

  uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .STOP_BITS(2)) dut1 (
    .CLK (CLK), .reset_trigger (reset_trigger), .din_if (if1),
    .tx (tx_w[1]), .busy (busy_w[1]), .level (lvl_w[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending bytes, and the byte currently framed with its cycle offset.
  logic [7:0] mq [2][$];
  bit         in_frame [2];
  int         t        [2];
  logic [7:0] cur      [2];
  int         flen     [2];
  bit         acc      [2];

  logic       drv_valid [2];
  logic [7:0] drv_data  [2];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
    end
  endtask

  function automatic logic exp_line(input int i);
    if (!in_frame[i]) return 1'b1;
    if (t[i] < CPB) return 1'b0;
    if (t[i] < 9 * CPB) return cur[i][t[i] / CPB - 1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      in_frame[i] = 1'b0;
      t[i]        = 0;
      acc[i]      = 1'b0;
      drv_valid[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input int i);
    bit rdy;
    rdy = (mq[i].size() < DEPTH);
    if (in_frame[i]) begin
      t[i]++;
      if (t[i] == flen[i]) begin
        if (mq[i].size() > 0) begin
          cur[i] = mq[i].pop_front();
          t[i]   = 0;
        end else begin
          in_frame[i] = 1'b0;
        end
      end
    end else if (mq[i].size() > 0) begin
      cur[i]      = mq[i].pop_front();
      t[i]        = 0;
      in_frame[i] = 1'b1;
    end
    acc[i] = drv_valid[i] && rdy;
    if (acc[i]) mq[i].push_back(drv_data[i]);
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("tx%0d", i),    32'(tx_w[i]),   32'(exp_line(i)));
      check_val($sformatf("busy%0d", i),  32'(busy_w[i]), 32'(in_frame[i] || (mq[i].size() != 0)));
      check_val($sformatf("level%0d", i), 32'(lvl_w[i]),  32'(mq[i].size()));
      check_val($sformatf("ready%0d", i), 32'(rdy_w[i]),  32'(mq[i].size() < DEPTH));
    end
  endtask

  task automatic cycle();
    if0.din_valid = drv_valid[0];
    if0.din       = drv_data[0];
    if1.din_valid = drv_valid[1];
    if1.din       = drv_data[1];
    @(posedge CLK);
    model_edge(0);
    model_edge(1);
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic idle(input int n);
    drv_valid[0] = 1'b0;
    drv_valid[1] = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic push_both(input logic [7:0] b);
    drv_valid[0] = 1'b1; drv_data[0] = b;
    drv_valid[1] = 1'b1; drv_data[1] = b;
    cycle();
    drv_valid[0] = 1'b0;
    drv_valid[1] = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges; line and status must settle without a clock.
  task automatic async_reset(input string tag);
    drv_valid[0] = 1'b0;
    drv_valid[1] = 1'b0;
    if0.din_valid = 1'b0;
    if1.din_valid = 1'b0;
    #2 reset_trigger = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("%s_tx%0d", tag, i),    32'(tx_w[i]),   32'd1);
      check_val($sformatf("%s_busy%0d", tag, i),  32'(busy_w[i]), 32'd0);
      check_val($sformatf("%s_level%0d", tag, i), 32'(lvl_w[i]),  32'd0);
      check_val($sformatf("%s_ready%0d", tag, i), 32'(rdy_w[i]),  32'd1);
    end
    @(negedge CLK);
    reset_trigger = 1'b0;
  endtask

  initial begin
    logic [7:0] nxt [2];
    int         cnt [2];
    bit         reached;
    flen[0] = 10 * CPB;
    flen[1] = 11 * CPB;
    for (int i = 0; i < 2; i++) drv_data[i] = 8'h00;
    if0.din = 8'h00; if0.din_valid = 1'b0;
    if1.din = 8'h00; if1.din_valid = 1'b0;
    reset_trigger = 1'b0;
    @(negedge CLK);
    async_reset("rst");

    // Single frame, then three back-to-back frames.
    push_both(8'hA5);
    idle(50);
    push_both(8'h00);
    drv_valid[0] = 1'b1; drv_data[0] = 8'hFF;
    drv_valid[1] = 1'b1; drv_data[1] = 8'hFF;
    cycle();
    push_both(8'h55);
    idle(150);

    // Producer holds din_valid with incrementing data until five bytes are taken.
    for (int i = 0; i < 2; i++) begin nxt[i] = 8'h10; cnt[i] = 0; end
    for (int k = 0; k < 400 && (cnt[0] < 5 || cnt[1] < 5); k++) begin
      for (int i = 0; i < 2; i++) begin
        drv_valid[i] = (cnt[i] < 5);
        drv_data[i]  = nxt[i];
      end
      cycle();
      for (int i = 0; i < 2; i++) if (acc[i]) begin nxt[i]++; cnt[i]++; end
    end
    check_val("hold_taken0", 32'(cnt[0]), 32'd5);
    check_val("hold_taken1", 32'(cnt[1]), 32'd5);
    idle(260);

    // Reset in the middle of a data bit of 0xC3 with two bytes still queued.
    push_both(8'hC3);
    push_both(8'h11);
    push_both(8'h22);
    reached = 1'b0;
    for (int k = 0; k < 100 && !reached; k++) begin
      if (in_frame[0] && t[0] == 3 * CPB + 1) reached = 1'b1;
      else cycle();
    end
    check_val("mid_reach", 32'(reached), 32'd1);
    check_val("mid_queued", 32'(lvl_w[0]), 32'd2);
    async_reset("mid");
    push_both(8'h81);
    idle(60);

    // Keep the FIFO around level 2 so pushes coincide with pops; pointers wrap several times.
    for (int i = 0; i < 2; i++) begin nxt[i] = 8'hE0; cnt[i] = 0; end
    for (int k = 0; k < 600 && (cnt[0] < 10 || cnt[1] < 10); k++) begin
      for (int i = 0; i < 2; i++) begin
        drv_valid[i] = (cnt[i] < 10) && (mq[i].size() <= 2);
        drv_data[i]  = nxt[i];
      end
      cycle();
      for (int i = 0; i < 2; i++) if (acc[i]) begin nxt[i]++; cnt[i]++; end
    end
    check_val("wrap_taken0", 32'(cnt[0]), 32'd10);
    check_val("wrap_taken1", 32'(cnt[1]), 32'd10);
    idle(200);

    // Random traffic; a refused byte is held until accepted.
    for (int i = 0; i < 2; i++) drv_valid[i] = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!drv_valid[i] || acc[i]) begin
          drv_valid[i] = ($urandom_range(0, 3) == 0);
          drv_data[i]  = 8'($urandom);
        end
      end
      cycle();
    end
    idle(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
